pid_ctrl_gen: RTL and testbench

//  Parametrised eBike PID motor controller. Converts signed torque error into unsigned drive magnitude.

---
 rtl/pid_pkg.sv | 14 +
 rtl/pid_decimator.sv | 31 +++
 rtl/pid_ctrl_gen.sv | 140 ++++++++++++++
 tb/tb_pid_ctrl_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared constants and helpers for the PID motor controller.
package pid_pkg;

  localparam int D_SAT_MAX  = 255;
  localparam int D_SAT_MIN  = -256;
  localparam int FAST_DEC_W = 15;

  function automatic int sat_signed(input int v, input int lo, input int hi);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pid_decimator.sv
// Free-running decimation counter; tick is high for the single all-ones count.
module pid_decimator
  import pid_pkg::*;
#(
  parameter int DEC_W    = 20,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DEC_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + DEC_W'(1);
  end

  generate
    if (FAST_SIM) begin : g_fast
      if (DEC_W < FAST_DEC_W) begin : g_bad_w
        $error("pid_decimator: FAST_SIM needs DEC_W >= %0d", FAST_DEC_W);
      end
      assign tick = &cnt[FAST_DEC_W-1:0];
    end else begin : g_full
      assign tick = &cnt;
    end
  endgenerate

endmodule

// File: rtl/pid_ctrl_gen.sv
// eBike PID controller: signed torque error in, clamped unsigned drive magnitude out,
// with a decimated integrator, a tick-sampled D history and a 2-stage output pipeline.
module pid_ctrl_gen
  import pid_pkg::*;
#(
  parameter int ERR_W    = 13,
  parameter int OUT_W    = 12,
  parameter int INT_W    = 18,
  parameter int DEC_W    = 20,
  parameter bit FAST_SIM = 1'b0,
  parameter int D_DEPTH  = 3,
  parameter int KI_SHIFT = 5,
  parameter int KD_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             not_pedaling,
  input  logic             err_vld,
  input  logic [ERR_W-1:0] error,
  output logic [OUT_W-1:0] drv_mag,
  output logic             drv_vld,
  output logic             sat_flag,
  output logic             tick
);

  localparam int SUM_W  = ERR_W + 2;
  localparam int STAGES = 1;
  localparam logic signed [INT_W:0]   INT_MAX = (INT_W+1)'((1 << (INT_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << OUT_W) - 1);

  generate
    if (INT_W - 1 - KI_SHIFT > ERR_W) begin : g_chk_ki
      $error("pid_ctrl_gen: INT_W-1-KI_SHIFT must be <= ERR_W");
    end
    if (9 + KD_SHIFT > ERR_W) begin : g_chk_kd
      $error("pid_ctrl_gen: 9+KD_SHIFT must be <= ERR_W");
    end
    if (D_DEPTH < 1) begin : g_chk_dd
      $error("pid_ctrl_gen: D_DEPTH must be >= 1");
    end
    if (OUT_W > ERR_W) begin : g_chk_out
      $error("pid_ctrl_gen: OUT_W must be <= ERR_W");
    end
  endgenerate

  pid_decimator #(
    .DEC_W    (DEC_W),
    .FAST_SIM (FAST_SIM)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic signed [ERR_W-1:0]        err_reg;
  logic signed [ERR_W-1:0]        err_nxt;
  logic [INT_W-1:0]               integ;
  logic signed [INT_W:0]          isum;
  logic [D_DEPTH-1:0][ERR_W-1:0]  hist;
  logic signed [ERR_W:0]          d_diff;
  logic signed [8:0]              d_sat;
  logic signed [SUM_W-1:0]        p_term, i_term, d_term;
  logic signed [SUM_W-1:0]        p_s1, i_s1, d_s1;
  logic signed [SUM_W-1:0]        sum_s2;
  logic [STAGES:0]                vld_pipe;

  // Stage 1 samples the value err_reg is about to take, so a captured error
  // reaches drv_mag exactly two clocks after its err_vld cycle.
  assign err_nxt = err_vld ? $signed(error) : err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_reg <= '0;
    else if (err_vld) err_reg <= $signed(error);
  end

  assign isum = $signed({1'b0, integ}) + (INT_W+1)'(err_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               integ <= '0;
    else if (not_pedaling) integ <= '0;
    else if (tick) begin
      if (isum > INT_MAX)  integ <= INT_MAX[INT_W-1:0];
      else if (isum < 0)   integ <= '0;
      else                 integ <= isum[INT_W-1:0];
    end
  end

  // History ignores not_pedaling so D stays meaningful when pedalling resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else if (tick) begin
      hist[0] <= err_reg;
      for (int k = 1; k < D_DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  assign d_diff = (ERR_W+1)'(err_nxt) - (ERR_W+1)'($signed(hist[D_DEPTH-1]));
  assign d_sat  = 9'(sat_signed(int'(d_diff), D_SAT_MIN, D_SAT_MAX));

  assign p_term = SUM_W'(err_nxt);
  assign i_term = SUM_W'({1'b0, integ[INT_W-2:KI_SHIFT]});
  assign d_term = SUM_W'(d_sat) <<< KD_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_s1     <= '0;
      i_s1     <= '0;
      d_s1     <= '0;
      vld_pipe <= '0;
    end else begin
      p_s1     <= p_term;
      i_s1     <= i_term;
      d_s1     <= d_term;
      vld_pipe <= {vld_pipe[STAGES-1:0], err_vld};
    end
  end

  assign sum_s2 = p_s1 + i_s1 + d_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_mag  <= '0;
      sat_flag <= 1'b0;
    end else if (vld_pipe[0]) begin
      if (sum_s2 < 0) begin
        drv_mag  <= '0;
        sat_flag <= 1'b1;
      end else if (sum_s2 > OUT_MAX) begin
        drv_mag  <= '1;
        sat_flag <= 1'b1;
      end else begin
        drv_mag  <= sum_s2[OUT_W-1:0];
        sat_flag <= 1'b0;
      end
    end
  end

  assign drv_vld = vld_pipe[STAGES];

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Randomised and directed bench for pid_ctrl_gen against a cycle-level integer model.
module tb_pid_ctrl_gen;

  localparam int ERR_W = 13, OUT_W = 12, INT_W = 18, DEC_W = 7;
  localparam int D_DEPTH = 3, KI_SHIFT = 5, KD_SHIFT = 2;
  localparam int DEC_MAX = (1 << DEC_W) - 1;
  localparam int INT_MAX = (1 << (INT_W - 1)) - 1;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  logic rst, not_pedaling, err_vld;
  logic [ERR_W-1:0] error;
  logic [OUT_W-1:0] drv_mag;
  logic drv_vld, sat_flag, tick;

  int checks = 0, failures = 0;

  // reference model state
  int m_err, m_integ, m_cnt, m_p, m_i, m_d, m_mag;
  bit m_vld1, m_dvld, m_sat;
  int m_hist[D_DEPTH];

  always #5 clk = ~clk;

  pid_ctrl_gen #(
    .ERR_W(ERR_W), .OUT_W(OUT_W), .INT_W(INT_W), .DEC_W(DEC_W), .FAST_SIM(1'b0),
    .D_DEPTH(D_DEPTH), .KI_SHIFT(KI_SHIFT), .KD_SHIFT(KD_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .not_pedaling(not_pedaling), .err_vld(err_vld), .error(error),
    .drv_mag(drv_mag), .drv_vld(drv_vld), .sat_flag(sat_flag), .tick(tick)
  );

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void m_clear();
    m_err = 0; m_integ = 0; m_cnt = 0; m_p = 0; m_i = 0; m_d = 0; m_mag = 0;
    m_vld1 = 0; m_dvld = 0; m_sat = 0;
    for (int k = 0; k < D_DEPTH; k++) m_hist[k] = 0;
  endfunction

  function automatic void model_step();
    int en, s;
    bit tk;
    tk = (m_cnt == DEC_MAX);
    en = err_vld ? int'($signed(error)) : m_err;
    if (m_vld1) begin
      s = m_p + m_i + m_d;
      if (s < 0)            begin m_mag = 0;       m_sat = 1; end
      else if (s > OUT_MAX) begin m_mag = OUT_MAX; m_sat = 1; end
      else                  begin m_mag = s;       m_sat = 0; end
    end
    m_dvld = m_vld1;
    m_vld1 = err_vld;
    m_p = en;
    m_i = m_integ >> KI_SHIFT;
    m_d = clampi(en - m_hist[D_DEPTH-1], -256, 255) * (1 << KD_SHIFT);
    if (not_pedaling) m_integ = 0;
    else if (tk)      m_integ = clampi(m_integ + m_err, 0, INT_MAX);
    if (tk) begin
      for (int k = D_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_err;
    end
    m_err = en;
    m_cnt = (m_cnt + 1) % (DEC_MAX + 1);
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) m_clear();
    else     model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; not_pedaling = 0; err_vld = 0; error = '0; m_clear();
    repeat (3) cycle();
    checks += 4;
    if (drv_mag !== 0)  begin failures++; $display("FAIL reset_mag: got %0h want 0", drv_mag); end
    if (drv_vld !== 0)  begin failures++; $display("FAIL reset_vld: got %0b want 0", drv_vld); end
    if (sat_flag !== 0) begin failures++; $display("FAIL reset_sat: got %0b want 0", sat_flag); end
    if (tick !== 0)     begin failures++; $display("FAIL reset_tick: got %0b want 0", tick); end
    rst = 0;
    err_vld = 1;
    for (int i = 0; i < 6; i++) begin
      error = ERR_W'(int'($urandom_range(0, 800)) - 400);
      cycle();
    end
    checks++;
    if (drv_vld !== 1'b1) begin failures++; $display("FAIL stream_vld: got %0b want 1", drv_vld); end
    rst = 1; m_clear();
    #1;
    checks += 2;
    if (drv_vld !== 0) begin failures++; $display("FAIL midrst_vld: got %0b want 0", drv_vld); end
    if (drv_mag !== 0) begin failures++; $display("FAIL midrst_mag: got %0h want 0", drv_mag); end
    err_vld = 0;
    cycle();
    rst = 0;
    error = '0; err_vld = 1;
    cycle();
    err_vld = 0;
    checks++;
    if (drv_vld !== 0) begin failures++; $display("FAIL rel_vld_p1: got %0b want 0", drv_vld); end
    cycle();
    checks += 2;
    if (drv_vld !== 1) begin failures++; $display("FAIL rel_vld_p2: got %0b want 1", drv_vld); end
    if (drv_mag !== 0) begin failures++; $display("FAIL rel_mag: got %0h want 0", drv_mag); end
  endtask

  task automatic test_pd_pre_tick();
    error = 13'h0100; err_vld = 1;
    cycle();
    err_vld = 0;
    cycle();
    checks += 3;
    if (drv_vld !== 1)        begin failures++; $display("FAIL pd_vld: got %0b want 1", drv_vld); end
    if (drv_mag !== 12'h4FC)  begin failures++; $display("FAIL pd_mag: got %0h want 4fc", drv_mag); end
    if (sat_flag !== 0)       begin failures++; $display("FAIL pd_sat: got %0b want 0", sat_flag); end
  endtask

  task automatic test_negative();
    error = 13'h1F00; err_vld = 1;
    cycle();
    err_vld = 0;
    cycle();
    checks += 2;
    if (drv_mag !== 0)  begin failures++; $display("FAIL neg_mag: got %0h want 0", drv_mag); end
    if (sat_flag !== 1) begin failures++; $display("FAIL neg_sat: got %0b want 1", sat_flag); end
  endtask

  task automatic test_windup();
    error = 13'h0FFF; err_vld = 1;
    for (int i = 0; i < 45 * (DEC_MAX + 1); i++) begin
      cycle();
      if (i % 16 == 0) begin
        checks += 2;
        if (dut.integ !== INT_W'(m_integ)) begin
          failures++; $display("FAIL windup_integ: got %0h want %0h", dut.integ, m_integ);
        end
        if (drv_mag !== OUT_W'(m_mag)) begin
          failures++; $display("FAIL windup_mag: got %0h want %0h", drv_mag, m_mag);
        end
      end
    end
    checks += 3;
    if (dut.integ !== 18'h1FFFF) begin failures++; $display("FAIL windup_max: got %0h want 1ffff", dut.integ); end
    if (drv_mag !== 12'hFFF)     begin failures++; $display("FAIL windup_out: got %0h want fff", drv_mag); end
    if (sat_flag !== 1)          begin failures++; $display("FAIL windup_sat: got %0b want 1", sat_flag); end
    err_vld = 0;
  endtask

  task automatic wait_tick_cycle(input string tag);
    int n = 0;
    while (m_cnt != DEC_MAX && n < DEC_MAX + 2) begin
      cycle();
      n++;
    end
    checks++;
    if (tick !== 1) begin failures++; $display("FAIL %s_tick: got %0b want 1", tag, tick); end
  endtask

  task automatic test_not_pedaling();
    rst = 1; m_clear(); cycle(); rst = 0;
    error = 13'h0100; err_vld = 1;
    cycle();
    err_vld = 0;
    wait_tick_cycle("np_first");
    cycle();
    checks++;
    if (dut.integ !== 18'h100) begin failures++; $display("FAIL np_pre: got %0h want 100", dut.integ); end
    error = 13'h0080; err_vld = 1;
    cycle();
    err_vld = 0;
    wait_tick_cycle("np_second");
    not_pedaling = 1;
    cycle();
    not_pedaling = 0;
    checks += 3;
    if (dut.integ !== 0)           begin failures++; $display("FAIL np_clear: got %0h want 0", dut.integ); end
    if (dut.hist[0] !== 13'h080)   begin failures++; $display("FAIL np_hist0: got %0h want 80", dut.hist[0]); end
    if (dut.hist[1] !== 13'h100)   begin failures++; $display("FAIL np_hist1: got %0h want 100", dut.hist[1]); end
  endtask

  task automatic test_handshake();
    bit pat[8] = '{0, 1, 0, 0, 1, 0, 0, 0};
    logic [OUT_W-1:0] prev;
    err_vld = 0;
    repeat (3) cycle();
    prev = drv_mag;
    for (int i = 0; i < 8; i++) begin
      err_vld = pat[i];
      error = ERR_W'(int'($urandom_range(0, 1200)) - 600);
      cycle();
      if (i >= 1) begin
        checks += 2;
        if (drv_vld !== pat[i-1]) begin
          failures++; $display("FAIL hs_vld[%0d]: got %0b want %0b", i, drv_vld, pat[i-1]);
        end
        if (pat[i-1] == 0 && drv_mag !== prev) begin
          failures++; $display("FAIL hs_hold[%0d]: got %0h want %0h", i, drv_mag, prev);
        end else if (pat[i-1] == 1 && drv_mag !== OUT_W'(m_mag)) begin
          failures++; $display("FAIL hs_mag[%0d]: got %0h want %0h", i, drv_mag, m_mag);
        end
      end
      prev = drv_mag;
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 3000; i++) begin
      err_vld = ($urandom_range(0, 1) == 1);
      not_pedaling = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) error = ERR_W'($urandom);
      else error = ERR_W'(int'($urandom_range(0, 1400)) - 700);
      cycle();
      checks += 4;
      if (drv_vld !== m_dvld) begin failures++; $display("FAIL rnd_vld[%0d]: got %0b want %0b", i, drv_vld, m_dvld); end
      if (drv_mag !== OUT_W'(m_mag)) begin failures++; $display("FAIL rnd_mag[%0d]: got %0h want %0h", i, drv_mag, m_mag); end
      if (sat_flag !== m_sat) begin failures++; $display("FAIL rnd_sat[%0d]: got %0b want %0b", i, sat_flag, m_sat); end
      if (tick !== (m_cnt == DEC_MAX)) begin failures++; $display("FAIL rnd_tick[%0d]: got %0b want %0b", i, tick, m_cnt == DEC_MAX); end
    end
    not_pedaling = 0; err_vld = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pd_pre_tick();
    test_negative();
    test_windup();
    test_not_pedaling();
    test_handshake();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
